// File: rtl/id_stage_pipe.sv
`timescale 1ns/1ps
// id_stage_pipe
// Instruction-decode stage with a registered ID/EX output. It decodes the
// 32-bit instruction, reads scalar/vector operands from internal register
// files (with optional same-cycle write-back bypass), and interlocks on
// RAW/WAW hazards through per-register scoreboards.
//
// Handshake: a transfer happens on a clk edge where valid && ready are both 1.
// in_ready does not depend on out_valid alone; the stage accepts when it has
// no hazard, no flush, and the ID/EX register is empty or being drained.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr   fetch side
//   flush                    discard the held ID/EX instruction
//   out_valid/out_ready      execute side
//   out_opcode, out_aluop, out_rd, out_rs1, out_rs2, out_imm, out_addr
//   out_a, out_b, out_va, out_vb, out_wr_s, out_wr_v
//   wb_we, wb_vwe, wb_rd, wb_data   write-back into the register files
//   stall_cnt                saturating count of hazard-stall cycles
module id_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int LANES     = 4,
  parameter int WB_BYPASS = 1,
  localparam int VLEN     = LANES * XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_opcode,
  output logic [2:0]      out_aluop,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_addr,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [VLEN-1:0] out_va,
  output logic [VLEN-1:0] out_vb,
  output logic            out_wr_s,
  output logic            out_wr_v,
  input  logic            wb_we,
  input  logic            wb_vwe,
  input  logic [4:0]      wb_rd,
  input  logic [VLEN-1:0] wb_data,
  output logic [15:0]     stall_cnt
);

  localparam bit BYP = (WB_BYPASS != 0);

  logic [XLEN-1:0] r_rf_s [32];
  logic [VLEN-1:0] r_rf_v [32];
  logic [31:0]     r_sb_s, r_sb_v;
  logic [15:0]     r_stall_cnt;

  // Decode
  logic [4:0] w_opc, w_f_rd, w_f_rs1, w_f_rs2, w_src1, w_src2;
  logic       w_use1_s, w_use2_s, w_use1_v, w_use2_v, w_wr_s, w_wr_v;

  assign w_opc   = in_instr[31:27];
  assign w_f_rd  = in_instr[26:22];
  assign w_f_rs1 = in_instr[21:17];
  assign w_f_rs2 = in_instr[16:12];

  always_comb begin
    w_src1 = 5'd0; w_src2 = 5'd0;
    w_use1_s = 1'b0; w_use2_s = 1'b0; w_use1_v = 1'b0; w_use2_v = 1'b0;
    w_wr_s = 1'b0; w_wr_v = 1'b0;
    case (w_opc[4:3])
      2'b00: begin
        w_src1 = w_f_rs1; w_src2 = w_f_rs2;
        w_use1_s = 1'b1; w_use2_s = 1'b1; w_wr_s = 1'b1;
      end
      2'b01: begin
        if (!w_opc[2]) begin
          w_src1 = w_f_rs1; w_use1_s = 1'b1; w_wr_s = 1'b1;
        end else begin
          w_src1 = w_f_rd; w_src2 = w_f_rs1; w_use1_s = 1'b1; w_use2_s = 1'b1;
        end
      end
      2'b10: begin
        if (!w_opc[2]) begin
          w_src1 = w_f_rs1; w_src2 = w_f_rs2;
          w_use1_v = 1'b1; w_use2_v = 1'b1; w_wr_v = 1'b1;
        end else begin
          w_src1 = w_f_rd; w_src2 = w_f_rs1; w_use1_v = 1'b1; w_use2_v = 1'b1;
        end
      end
      default: begin
        if (w_opc[2]) begin
          w_src1 = w_f_rd; w_src2 = w_f_rs1; w_use1_s = 1'b1; w_use2_s = 1'b1;
        end
      end
    endcase
  end

  // Write-back masks; scalar r0 is never tracked.
  logic [31:0] w_wb_s_mask, w_wb_v_mask, w_vis_s, w_vis_v;
  assign w_wb_s_mask = (wb_we && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0;
  assign w_wb_v_mask = wb_vwe ? (32'd1 << wb_rd) : 32'd0;
  // With bypass, a bit being cleared this cycle no longer blocks the reader.
  assign w_vis_s = BYP ? (r_sb_s & ~w_wb_s_mask) : r_sb_s;
  assign w_vis_v = BYP ? (r_sb_v & ~w_wb_v_mask) : r_sb_v;

  logic w_hazard, w_accept;
  assign w_hazard = in_valid && ((w_use1_s && w_vis_s[w_src1]) ||
                                 (w_use2_s && w_vis_s[w_src2]) ||
                                 (w_use1_v && w_vis_v[w_src1]) ||
                                 (w_use2_v && w_vis_v[w_src2]) ||
                                 (w_wr_s && w_vis_s[w_f_rd]) ||
                                 (w_wr_v && w_vis_v[w_f_rd]));
  assign in_ready = !w_hazard && !flush && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Operand reads with optional write-back forwarding.
  logic [XLEN-1:0] w_a, w_b;
  logic [VLEN-1:0] w_va, w_vb;
  always_comb begin
    w_a = '0; w_b = '0; w_va = '0; w_vb = '0;
    if (w_use1_s && w_src1 != 5'd0)
      w_a = (BYP && wb_we && wb_rd == w_src1) ? wb_data[XLEN-1:0] : r_rf_s[w_src1];
    if (w_use2_s && w_src2 != 5'd0)
      w_b = (BYP && wb_we && wb_rd == w_src2) ? wb_data[XLEN-1:0] : r_rf_s[w_src2];
    if (w_use1_v)
      w_va = (BYP && wb_vwe && wb_rd == w_src1) ? wb_data : r_rf_v[w_src1];
    if (w_use2_v)
      w_vb = (BYP && wb_vwe && wb_rd == w_src2) ? wb_data : r_rf_v[w_src2];
  end

  // Scoreboard update: set by acceptance wins over write-back/flush clears.
  // A flush only retracts the bit of an instruction execute did not take.
  logic        w_discard;
  logic [31:0] w_set_s, w_set_v, w_fl_s, w_fl_v;
  assign w_discard = flush && out_valid && !out_ready;
  assign w_set_s = (w_accept && w_wr_s && w_f_rd != 5'd0) ? (32'd1 << w_f_rd) : 32'd0;
  assign w_set_v = (w_accept && w_wr_v) ? (32'd1 << w_f_rd) : 32'd0;
  assign w_fl_s  = (w_discard && out_wr_s) ? (32'd1 << out_rd) : 32'd0;
  assign w_fl_v  = (w_discard && out_wr_v) ? (32'd1 << out_rd) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_s <= '0;
      r_sb_v <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_sb_s <= (r_sb_s & ~w_wb_s_mask & ~w_fl_s) | w_set_s;
      r_sb_v <= (r_sb_v & ~w_wb_v_mask & ~w_fl_v) | w_set_v;
      if (w_hazard && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_rf_s[i] <= '0;
        r_rf_v[i] <= '0;
      end
    end else begin
      if (wb_we && wb_rd != 5'd0) r_rf_s[wb_rd] <= wb_data[XLEN-1:0];
      if (wb_vwe) r_rf_v[wb_rd] <= wb_data;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; out_opcode <= '0; out_aluop <= '0;
      out_rd <= '0; out_rs1 <= '0; out_rs2 <= '0;
      out_imm <= '0; out_addr <= '0; out_a <= '0; out_b <= '0;
      out_va <= '0; out_vb <= '0; out_wr_s <= 1'b0; out_wr_v <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid  <= 1'b1;
      out_opcode <= w_opc;
      out_aluop  <= in_instr[11:9];
      out_rd     <= w_f_rd;
      out_rs1    <= w_src1;
      out_rs2    <= w_src2;
      out_imm    <= {{(XLEN-16){in_instr[16]}}, in_instr[16:1]};
      out_addr   <= {{(XLEN-27){1'b0}}, in_instr[26:0]};
      out_a      <= w_a;
      out_b      <= w_b;
      out_va     <= w_va;
      out_vb     <= w_vb;
      out_wr_s   <= w_wr_s;
      out_wr_v   <= w_wr_v;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
`timescale 1ns/1ps
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int VLEN = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [4:0]      out_opcode, out_rd, out_rs1, out_rs2, wb_rd;
  logic [2:0]      out_aluop;
  logic [XLEN-1:0] out_imm, out_addr, out_a, out_b;
  logic [VLEN-1:0] out_va, out_vb, wb_data;
  logic            out_wr_s, out_wr_v, wb_we, wb_vwe;
  logic [15:0]     stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall = 0;

  id_stage_pipe #(.XLEN(32), .LANES(4), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_aluop(out_aluop),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_addr(out_addr), .out_a(out_a), .out_b(out_b), .out_va(out_va),
    .out_vb(out_vb), .out_wr_s(out_wr_s), .out_wr_v(out_wr_v), .wb_we(wb_we),
    .wb_vwe(wb_vwe), .wb_rd(wb_rd), .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {opc, rd, rs1, rs2, 12'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_scalar(input logic [4:0] rd, input logic [31:0] data);
    wb_we = 1'b1; wb_rd = rd; wb_data = {96'd0, data};
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_vwe = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_a !== 32'd0) begin n_err++; $display("FAIL rst_a got=%h exp=0", out_a); end
    n_cmp++; if (out_va !== 128'd0) begin n_err++; $display("FAIL rst_va got=%h exp=0", out_va); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_stall got=%h exp=0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    wb_scalar(5'd1, 32'd5);
    wb_scalar(5'd2, 32'd7);
    wb_scalar(5'd6, 32'h66);
    wb_scalar(5'd8, 32'h88);
    in_valid = 1'b1; in_instr = mk(5'b00000, 5'd3, 5'd1, 5'd2);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL alu_in_ready got=%b exp=1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL alu_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_a !== 32'd5) begin n_err++; $display("FAIL alu_a got=%h exp=5", out_a); end
    n_cmp++; if (out_b !== 32'd7) begin n_err++; $display("FAIL alu_b got=%h exp=7", out_b); end
    n_cmp++; if (out_rd !== 5'd3 || out_wr_s !== 1'b1) begin n_err++; $display("FAIL alu_rd got=%0d/%b exp=3/1", out_rd, out_wr_s); end
  endtask

  // Entered one cycle after the ALU op was accepted: r3 is pending.
  task automatic test_back_to_back();
    in_instr = mk(5'b00000, 5'd3, 5'd3, 5'd1);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
      exp_stall++;
      n_cmp++; if (stall_cnt !== exp_stall[15:0]) begin n_err++; $display("FAIL b2b_stall_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, exp_stall); end
    end
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 128'h55;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_bypass_ready got=%b exp=1", in_ready); end
    tick();
    wb_we = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'h55) begin n_err++; $display("FAIL b2b_bypass_a got=%b/%h exp=1/55", out_valid, out_a); end
    n_cmp++; if (out_b !== 32'd5) begin n_err++; $display("FAIL b2b_b got=%h exp=5", out_b); end
    n_cmp++; if (stall_cnt !== exp_stall[15:0]) begin n_err++; $display("FAIL b2b_no_count got=%0d exp=%0d", stall_cnt, exp_stall); end
    // r3 was set again by the accepted instruction: a reader must stall.
    in_valid = 1'b1; in_instr = mk(5'b00000, 5'd7, 5'd3, 5'd0);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_resets_sb got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    wb_scalar(5'd3, 32'h55);
  endtask

  task automatic test_vector();
    in_valid = 1'b1; in_instr = mk(5'b10000, 5'd9, 5'd4, 5'd4);
    wb_vwe = 1'b1; wb_rd = 5'd4; wb_data = 128'h0001_0002_0003_0004;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL vec_ready got=%b exp=1", in_ready); end
    tick();
    wb_vwe = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_va !== 128'h0001_0002_0003_0004) begin n_err++; $display("FAIL vec_va got=%h exp=00010002_00030004", out_va); end
    n_cmp++; if (out_vb !== 128'h0001_0002_0003_0004) begin n_err++; $display("FAIL vec_vb got=%h exp=00010002_00030004", out_vb); end
    n_cmp++; if (out_wr_v !== 1'b1 || out_wr_s !== 1'b0 || out_a !== 32'd0) begin n_err++; $display("FAIL vec_flags got=%b/%b/%h exp=1/0/0", out_wr_v, out_wr_s, out_a); end
    // v9 now pending; a same-cycle write-back of v9 releases the reader.
    in_valid = 1'b1; in_instr = mk(5'b10000, 5'd10, 5'd9, 5'd9);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL vec_hazard got=%b exp=0", in_ready); end
    wb_vwe = 1'b1; wb_rd = 5'd9; wb_data = 128'h0000_0009_0000_0008_0000_0007_0000_0006;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL vec_release got=%b exp=1", in_ready); end
    tick();
    wb_vwe = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_va !== 128'h0000_0009_0000_0008_0000_0007_0000_0006) begin n_err++; $display("FAIL vec_va2 got=%h", out_va); end
  endtask

  task automatic test_store();
    in_valid = 1'b1; in_instr = mk(5'b01100, 5'd6, 5'd8, 5'd0);
    tick();
    n_cmp++; if (out_rs1 !== 5'd6 || out_rs2 !== 5'd8) begin n_err++; $display("FAIL st_specs got=%0d/%0d exp=6/8", out_rs1, out_rs2); end
    n_cmp++; if (out_wr_s !== 1'b0 || out_wr_v !== 1'b0) begin n_err++; $display("FAIL st_wr got=%b/%b exp=0/0", out_wr_s, out_wr_v); end
    n_cmp++; if (out_a !== 32'h66 || out_b !== 32'h88) begin n_err++; $display("FAIL st_ops got=%h/%h exp=66/88", out_a, out_b); end
    in_instr = mk(5'b00000, 5'd14, 5'd6, 5'd8);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL st_no_sb got=%b exp=1", in_ready); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_jump();
    in_valid = 1'b1; in_instr = 32'hC001_0E02;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_opcode !== 5'b11000 || out_aluop !== 3'd7) begin n_err++; $display("FAIL jmp_opc got=%b/%0d exp=11000/7", out_opcode, out_aluop); end
    n_cmp++; if (out_imm !== 32'hFFFF_8701) begin n_err++; $display("FAIL jmp_imm got=%h exp=ffff8701", out_imm); end
    n_cmp++; if (out_addr !== 32'h0001_0E02) begin n_err++; $display("FAIL jmp_addr got=%h exp=00010e02", out_addr); end
    n_cmp++; if (out_rs1 !== 5'd0 || out_a !== 32'd0 || out_wr_s !== 1'b0) begin n_err++; $display("FAIL jmp_noread got=%0d/%h/%b exp=0/0/0", out_rs1, out_a, out_wr_s); end
  endtask

  task automatic test_r0();
    wb_scalar(5'd0, 32'hDEAD);
    in_valid = 1'b1; in_instr = mk(5'b00000, 5'd0, 5'd0, 5'd0);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 128'hBEEF;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready got=%b exp=1", in_ready); end
    tick();
    wb_we = 1'b0;
    n_cmp++; if (out_a !== 32'd0 || out_b !== 32'd0) begin n_err++; $display("FAIL r0_read got=%h/%h exp=0/0", out_a, out_b); end
    in_instr = mk(5'b00000, 5'd16, 5'd0, 5'd0);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_no_pending got=%b exp=1", in_ready); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(5'b00000, 5'd11, 5'd1, 5'd2);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept got=%b exp=1", in_ready); end
    tick();
    in_instr = mk(5'b00000, 5'd12, 5'd1, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'd5 || out_b !== 32'd7 || out_rd !== 5'd11) begin n_err++; $display("FAIL bp_hold[%0d] got=%b/%h/%h/%0d exp=1/5/7/11", i, out_valid, out_a, out_b, out_rd); end
      tick();
    end
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got=%b exp=0", out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; in_instr = mk(5'b00000, 5'd13, 5'd11, 5'd0);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_sb_cleared got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_rs1 !== 5'd11 || out_a !== 32'd0) begin n_err++; $display("FAIL fl_next got=%b/%0d/%h exp=1/11/0", out_valid, out_rs1, out_a); end
  endtask

  task automatic test_stall_sat();
    in_valid = 1'b1; in_instr = mk(5'b00000, 5'd15, 5'd13, 5'd0);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sat_hazard got=%b exp=0", in_ready); end
    repeat (65540) tick();
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt got=%h exp=ffff", stall_cnt); end
  endtask

  // Entered mid-stall: reset must act without waiting for a clock edge.
  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL arst_cnt got=%h exp=0", stall_cnt); end
    n_cmp++; if (out_valid !== 1'b0 || out_rs1 !== 5'd0) begin n_err++; $display("FAIL arst_out got=%b/%0d exp=0/0", out_valid, out_rs1); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_sb got=%b exp=1", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_vector();
    test_store();
    test_jump();
    test_r0();
    test_backpressure_flush();
    test_stall_sat();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
